// File: rtl/rv32i_lsu_bridge_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_lsu_bridge_pkg
// Shared definitions for the RV32I load/store bridge:
//   lsu_state_e     FSM state encoding (2-bit)
//   TIMEOUT_POISON  word returned to the ALU when a load is aborted by timeout
//   RD_BE_ALL       byte enables driven on every read (full word fetch)
//   word_align()    clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package rv32i_lsu_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } lsu_state_e;

  localparam logic [31:0] TIMEOUT_POISON = 32'hDEAD_BEEF;
  localparam logic [3:0]  RD_BE_ALL      = 4'b1111;

  // The ALU hands over word addresses; the low two bits carry no meaning here.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_lsu_bridge_if.sv
// ---------------------------------------------------------------------------
// rv32i_lsu_bridge_if
// Avalon-MM style memory bus between the load/store bridge (master) and the
// memory/interconnect (slave).
//   avm_address       master->slave  32  word address, [1:0] = 0
//   avm_byteenable    master->slave   4  byte enables (all ones on reads)
//   avm_writedata     master->slave  32  write data
//   avm_read          master->slave   1  read strobe
//   avm_write         master->slave   1  write strobe
//   avm_waitrequest   slave->master   1  slave not accepting this cycle
//   avm_readdata      slave->master  32  read data
//   avm_readdatavalid slave->master   1  read data valid
// ---------------------------------------------------------------------------
interface rv32i_lsu_bridge_if;

  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic        avm_write;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/rv32i_lsu_timeout.sv
// ---------------------------------------------------------------------------
// rv32i_lsu_timeout
// Per-access watchdog for the load/store bridge. Only compiled when the
// RV32_LSU_TIMEOUT_EN macro is defined; the default build has no watchdog.
// Ports:
//   clk     in  1  clock
//   reset   in  1  asynchronous, active-high
//   clear   in  1  hold the counter at zero (bridge idle)
//   enable  in  1  an access is in progress, count this cycle
//   expire  out 1  combinational: the current cycle is the last one allowed
// With enable held from the first busy cycle, expire asserts in the
// TIMEOUT_CYCLES-th busy cycle (counter value TIMEOUT_CYCLES-1).
// ---------------------------------------------------------------------------
`ifdef RV32_LSU_TIMEOUT_EN
module rv32i_lsu_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // Saturates at LAST so a stuck enable can never wrap into a fresh window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = enable & (count_reg == LAST);

endmodule
`endif

// File: rtl/rv32i_lsu_bridge.sv
// ---------------------------------------------------------------------------
// rv32i_lsu_bridge
// Memory stage behind the RV32I ALU. Takes a one-cycle load/store request,
// runs it as a single Avalon-MM access and stalls the pipeline until done.
// Loads return the raw 32-bit word; lane extraction stays in the ALU.
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   load, store    ALU request strobes (store wins if both are set)
//   addr           request address, [1:0] ignored
//   st_be, st_data store byte enables / lane-shifted data
//   stall          hold pipeline: busy, or a request is being presented
//   clr_load_op    one-cycle pulse when a load completes (or is aborted)
//   ld_data        last loaded word, held until the next load completes
//   bus_err        sticky access-timeout flag (0 without the watchdog)
//   avm            Avalon-MM master port (rv32i_lsu_bridge_if.master)
// Build option: define RV32_LSU_TIMEOUT_EN to enable the per-access
// watchdog (TIMEOUT_CYCLES); without it an access may wait forever.
// ---------------------------------------------------------------------------
module rv32i_lsu_bridge
  import rv32i_lsu_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned RD_OUTSTANDING = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     store,
  input  logic [31:0]              addr,
  input  logic [3:0]               st_be,
  input  logic [31:0]              st_data,
  output logic                     stall,
  output logic                     clr_load_op,
  output logic [31:0]              ld_data,
  output logic                     bus_err,
  rv32i_lsu_bridge_if.master       avm
);

  // The FSM tracks exactly one read in flight; nothing else is supported.
  if (RD_OUTSTANDING != 1) begin : g_bad_outstanding
    $error("rv32i_lsu_bridge: RD_OUTSTANDING must be 1");
  end

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rv32i_lsu_bridge: TIMEOUT_CYCLES must be at least 2");
  end

  lsu_state_e state_reg;
  logic       timeout_expire;

`ifdef RV32_LSU_TIMEOUT_EN
  rv32i_lsu_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg == IDLE),
    .enable (state_reg != IDLE),
    .expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // Requests stall the pipeline in the cycle they are presented, before the
  // FSM has left IDLE, so the ALU never advances past an unissued access.
  assign stall = (state_reg != IDLE) | load | store;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= IDLE;
      clr_load_op        <= 1'b0;
      ld_data            <= '0;
      bus_err            <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_byteenable <= '0;
      avm.avm_writedata  <= '0;
      avm.avm_read       <= 1'b0;
      avm.avm_write      <= 1'b0;
    end else begin
      clr_load_op <= 1'b0;

      case (state_reg)
        IDLE: begin
          // Store has priority: a simultaneous load is illegal and dropped.
          if (store) begin
            avm.avm_address    <= word_align(addr);
            avm.avm_byteenable <= st_be;
            avm.avm_writedata  <= st_data;
            avm.avm_write      <= 1'b1;
            state_reg          <= WR_REQ;
          end else if (load) begin
            avm.avm_address    <= word_align(addr);
            avm.avm_byteenable <= RD_BE_ALL;
            avm.avm_read       <= 1'b1;
            state_reg          <= RD_REQ;
          end
        end

        RD_REQ: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            // A zero-latency slave may return data in the accept cycle.
            if (avm.avm_readdatavalid) begin
              ld_data     <= avm.avm_readdata;
              clr_load_op <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              state_reg   <= RD_WAIT;
            end
          end else if (timeout_expire) begin
            avm.avm_read <= 1'b0;
            ld_data      <= TIMEOUT_POISON;
            clr_load_op  <= 1'b1;
            bus_err      <= 1'b1;
            state_reg    <= IDLE;
          end
        end

        RD_WAIT: begin
          if (avm.avm_readdatavalid) begin
            ld_data     <= avm.avm_readdata;
            clr_load_op <= 1'b1;
            state_reg   <= IDLE;
          end else if (timeout_expire) begin
            ld_data     <= TIMEOUT_POISON;
            clr_load_op <= 1'b1;
            bus_err     <= 1'b1;
            state_reg   <= IDLE;
          end
        end

        WR_REQ: begin
          // Posted write: acceptance completes it.
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            state_reg     <= IDLE;
          end else if (timeout_expire) begin
            avm.avm_write <= 1'b0;
            bus_err       <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu_bridge.sv
// ---------------------------------------------------------------------------
// tb_rv32i_lsu_bridge
// Scoreboard bench for rv32i_lsu_bridge. Expected bus accesses and load
// results are queued when a request is driven and checked by a monitor when
// the DUT strobes the bus or pulses clr_load_op. A small slave responder
// models waitrequest / readdatavalid timing.
// ---------------------------------------------------------------------------
module tb_rv32i_lsu_bridge;
  import rv32i_lsu_bridge_pkg::*;

  localparam int unsigned TO_CYC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  st_be = '0;
  logic [31:0] st_data = '0;
  logic        stall;
  logic        clr_load_op;
  logic [31:0] ld_data;
  logic        bus_err;

  rv32i_lsu_bridge_if avm_bus();

  rv32i_lsu_bridge #(
    .TIMEOUT_CYCLES (TO_CYC),
    .RD_OUTSTANDING (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .store       (store),
    .addr        (addr),
    .st_be       (st_be),
    .st_data     (st_data),
    .stall       (stall),
    .clr_load_op (clr_load_op),
    .ld_data     (ld_data),
    .bus_err     (bus_err),
    .avm         (avm_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_txn_t;

  logic [31:0] rd_addr_q[$];
  wr_txn_t     wr_q[$];
  logic [31:0] ld_q[$];

  // ---------------- slave responder ----------------
  int          wait_left = 0;
  bit          rdv_same = 1'b0;
  int          rdv_delay = 0;
  bit          rd_pending = 1'b0;
  int          rd_delay_left = 0;
  bit          stuck = 1'b0;
  logic [31:0] rd_word = '0;

  initial begin
    avm_bus.avm_waitrequest   = 1'b0;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      avm_bus.avm_readdatavalid = 1'b0;
      if (rd_pending) begin
        if (rd_delay_left == 0) begin
          avm_bus.avm_readdatavalid = 1'b1;
          avm_bus.avm_readdata      = rd_word;
          rd_pending                = 1'b0;
        end else begin
          rd_delay_left--;
        end
      end
      if (stuck) begin
        avm_bus.avm_waitrequest = 1'b1;
      end else if (avm_bus.avm_read || avm_bus.avm_write) begin
        if (wait_left > 0) begin
          avm_bus.avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_bus.avm_waitrequest = 1'b0;
          if (avm_bus.avm_read) begin
            if (rdv_same) begin
              avm_bus.avm_readdatavalid = 1'b1;
              avm_bus.avm_readdata      = rd_word;
            end else begin
              rd_pending    = 1'b1;
              rd_delay_left = rdv_delay;
            end
          end
        end
      end else begin
        avm_bus.avm_waitrequest = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] mon_exp;
  wr_txn_t     mon_wr;

  always @(negedge clk) begin
    if (!reset) begin
      if (avm_bus.avm_read) begin
        if (rd_addr_q.size() == 0) begin
          check("rd_unexpected_qsize", 32'(rd_addr_q.size()), 32'd1);
        end else begin
          check("rd_addr", avm_bus.avm_address, rd_addr_q[0]);
          check("rd_be", 32'(avm_bus.avm_byteenable), 32'h0000_000F);
          if (!avm_bus.avm_waitrequest) begin
            $display("[TB] read  accepted addr=0x%08h", avm_bus.avm_address);
            mon_exp = rd_addr_q.pop_front();
          end
        end
      end
      if (avm_bus.avm_write) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected_qsize", 32'(wr_q.size()), 32'd1);
        end else begin
          mon_wr = wr_q[0];
          check("wr_addr", avm_bus.avm_address, mon_wr.a);
          check("wr_be", 32'(avm_bus.avm_byteenable), 32'(mon_wr.be));
          check("wr_data", avm_bus.avm_writedata, mon_wr.d);
          if (!avm_bus.avm_waitrequest) begin
            $display("[TB] write accepted addr=0x%08h be=%b data=0x%08h",
                     avm_bus.avm_address, avm_bus.avm_byteenable, avm_bus.avm_writedata);
            mon_wr = wr_q.pop_front();
          end
        end
      end
      if (clr_load_op) begin
        if (ld_q.size() == 0) begin
          check("clr_unexpected_qsize", 32'(ld_q.size()), 32'd1);
        end else begin
          mon_exp = ld_q.pop_front();
          check("ld_data", ld_data, mon_exp);
          $display("[TB] load  complete data=0x%08h", ld_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1 with the DUT idle. Presents one request for one
  // cycle, then counts busy/strobe/pulse cycles over a fixed window that
  // starts with the first cycle after the request cycle.
  task automatic run_access(input bit do_ld, input bit do_st, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d,
                            input int waits, input bit same, input int win,
                            output int n_stall, output int n_rd,
                            output int n_wr, output int n_clr);
    wait_left = waits;
    rdv_same  = same;
    rdv_delay = 0;
    load    = do_ld;
    store   = do_st;
    addr    = a;
    st_be   = be;
    st_data = d;
    @(negedge clk);
    check("req_cycle_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    load    = 1'b0;
    store   = 1'b0;
    addr    = $urandom;
    st_be   = 4'($urandom);
    st_data = $urandom;
    n_stall = 0;
    n_rd    = 0;
    n_wr    = 0;
    n_clr   = 0;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      n_stall += int'(stall);
      n_rd    += int'(avm_bus.avm_read);
      n_wr    += int'(avm_bus.avm_write);
      n_clr   += int'(clr_load_op);
    end
    @(posedge clk);
    #1;
  endtask

  int ns, nr, nw, nc;
  wr_txn_t wt;

  initial begin
    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_clr", 32'(clr_load_op), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_read", 32'(avm_bus.avm_read), 32'd0);
    check("rst_write", 32'(avm_bus.avm_write), 32'd0);
    check("rst_address", avm_bus.avm_address, 32'd0);
    check("rst_be", 32'(avm_bus.avm_byteenable), 32'd0);
    check("rst_wdata", avm_bus.avm_writedata, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: zero-wait load, data the following cycle
    rd_word = 32'h1234_5678;
    rd_addr_q.push_back(32'h0000_0100);
    ld_q.push_back(32'h1234_5678);
    run_access(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 0, 1'b0, 12, ns, nr, nw, nc);
    check("t1_stall_cycles", 32'(ns), 32'd2);
    check("t1_read_cycles", 32'(nr), 32'd1);
    check("t1_write_cycles", 32'(nw), 32'd0);
    check("t1_clr_pulses", 32'(nc), 32'd1);

    // 2: store held off by three waitrequest cycles
    wt = '{a: 32'h0000_0204, be: 4'b0011, d: 32'h0000_ABCD};
    wr_q.push_back(wt);
    run_access(1'b0, 1'b1, 32'h0000_0204, 4'b0011, 32'h0000_ABCD, 3, 1'b0, 12, ns, nr, nw, nc);
    check("t2_stall_cycles", 32'(ns), 32'd4);
    check("t2_write_cycles", 32'(nw), 32'd4);
    check("t2_read_cycles", 32'(nr), 32'd0);
    check("t2_clr_pulses", 32'(nc), 32'd0);
    check("t2_ld_data_held", ld_data, 32'h1234_5678);

    // 3: data returned in the accept cycle; unaligned address bits dropped
    rd_word = 32'h89AB_CDEF;
    rd_addr_q.push_back(32'h0000_0108);
    ld_q.push_back(32'h89AB_CDEF);
    run_access(1'b1, 1'b0, 32'h0000_010B, 4'h0, 32'h0, 0, 1'b1, 12, ns, nr, nw, nc);
    check("t3_stall_cycles", 32'(ns), 32'd1);
    check("t3_read_cycles", 32'(nr), 32'd1);
    check("t3_clr_pulses", 32'(nc), 32'd1);

    // 3b: load held off by two waitrequest cycles
    rd_word = 32'h0F0F_0F0F;
    rd_addr_q.push_back(32'h0000_020C);
    ld_q.push_back(32'h0F0F_0F0F);
    run_access(1'b1, 1'b0, 32'h0000_020C, 4'h0, 32'h0, 2, 1'b0, 12, ns, nr, nw, nc);
    check("t3b_stall_cycles", 32'(ns), 32'd4);
    check("t3b_read_cycles", 32'(nr), 32'd3);
    check("t3b_clr_pulses", 32'(nc), 32'd1);

    // 4: load and store together: store wins
    wt = '{a: 32'h0000_0300, be: 4'b1111, d: 32'h55AA_55AA};
    wr_q.push_back(wt);
    run_access(1'b1, 1'b1, 32'h0000_0300, 4'b1111, 32'h55AA_55AA, 0, 1'b0, 12, ns, nr, nw, nc);
    check("t4_stall_cycles", 32'(ns), 32'd1);
    check("t4_write_cycles", 32'(nw), 32'd1);
    check("t4_read_cycles", 32'(nr), 32'd0);
    check("t4_clr_pulses", 32'(nc), 32'd0);
    check("t4_ld_data_held", ld_data, 32'h0F0F_0F0F);

    // 5: asynchronous reset while waiting for read data
    rd_word   = 32'h7777_7777;
    wait_left = 0;
    rdv_same  = 1'b0;
    rdv_delay = 3;
    rd_addr_q.push_back(32'h0000_0400);
    load = 1'b1;
    addr = 32'h0000_0400;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(posedge clk);
    #1;
    rdv_delay = 0;
    @(negedge clk);
    check("t5_busy_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_stall", 32'(stall), 32'd0);
    check("t5_rst_read", 32'(avm_bus.avm_read), 32'd0);
    check("t5_rst_ld_data", ld_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nc = 0;
    ns = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nc += int'(clr_load_op);
      ns += int'(stall);
    end
    check("t5_late_rdv_clr", 32'(nc), 32'd0);
    check("t5_late_rdv_stall", 32'(ns), 32'd0);
    check("t5_late_rdv_ld_data", ld_data, 32'd0);
    @(posedge clk);
    #1;

    // 6: slave never accepts
    stuck = 1'b1;
    rd_addr_q.push_back(32'h0000_0500);
`ifdef RV32_LSU_TIMEOUT_EN
    ld_q.push_back(32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, 32'h0000_0500, 4'h0, 32'h0, 0, 1'b0, 12, ns, nr, nw, nc);
    check("t6_stall_cycles", 32'(ns), TO_CYC);
    check("t6_read_cycles", 32'(nr), TO_CYC);
    check("t6_clr_pulses", 32'(nc), 32'd1);
    check("t6_bus_err", 32'(bus_err), 32'd1);
    rd_addr_q.delete();
    stuck = 1'b0;
`else
    run_access(1'b1, 1'b0, 32'h0000_0500, 4'h0, 32'h0, 0, 1'b0, 40, ns, nr, nw, nc);
    check("t6_stall_cycles", 32'(ns), 32'd40);
    check("t6_read_cycles", 32'(nr), 32'd40);
    check("t6_clr_pulses", 32'(nc), 32'd0);
    check("t6_bus_err", 32'(bus_err), 32'd0);
    reset = 1'b1;
    rd_addr_q.delete();
    stuck = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
`endif

    // recovery load after the stuck access
    rd_word = 32'h1357_9BDF;
    rd_addr_q.push_back(32'h0000_0600);
    ld_q.push_back(32'h1357_9BDF);
    run_access(1'b1, 1'b0, 32'h0000_0600, 4'h0, 32'h0, 0, 1'b0, 12, ns, nr, nw, nc);
    check("t7_clr_pulses", 32'(nc), 32'd1);
`ifdef RV32_LSU_TIMEOUT_EN
    check("t7_bus_err_sticky", 32'(bus_err), 32'd1);
`else
    check("t7_bus_err", 32'(bus_err), 32'd0);
`endif

    check("end_rd_q_empty", 32'(rd_addr_q.size()), 32'd0);
    check("end_wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("end_ld_q_empty", 32'(ld_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
